// File: rtl/ifu_fetch_if.sv
`default_nettype none
// =============================================================================
// Module   : ifu_fetch_if
// Brief    : Fetch-stage bundle: PC/stall, instruction bus and IF/ID signals.
//            Optional feature macro: IFU_MISALIGN_CHECK_EN
// Revision : 1.0 - initial release
// =============================================================================
interface ifu_fetch_if #(
   parameter int XLEN = 64
);
   logic [XLEN-1:0] pc_i;
   logic            flush_valid_i;
   logic            stall_req_o;
   logic            mem_req_valid_o;
   logic            mem_req_ready_i;
   logic [XLEN-1:0] mem_addr_o;
   logic            mem_rsp_valid_i;
   logic [XLEN-1:0] mem_rsp_data_i;
   logic            inst_valid_o;
   logic [31:0]     inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic            id_ready_i;
`ifdef IFU_MISALIGN_CHECK_EN
   logic            inst_misalign_o;
`endif

   // Directions are named from the fetch stage's point of view
   modport master (
      input  pc_i, flush_valid_i, mem_req_ready_i, mem_rsp_valid_i,
             mem_rsp_data_i, id_ready_i,
      output stall_req_o, mem_req_valid_o, mem_addr_o, inst_valid_o,
             inst_o, inst_pc_o
`ifdef IFU_MISALIGN_CHECK_EN
      , output inst_misalign_o
`endif
   );

   modport slave (
      output pc_i, flush_valid_i, mem_req_ready_i, mem_rsp_valid_i,
             mem_rsp_data_i, id_ready_i,
      input  stall_req_o, mem_req_valid_o, mem_addr_o, inst_valid_o,
             inst_o, inst_pc_o
`ifdef IFU_MISALIGN_CHECK_EN
      , input inst_misalign_o
`endif
   );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// =============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch: doubleword bus read for the PC, word select,
//            hand-off to ID, stall back-pressure and redirect flush handling.
//            Optional feature macro: IFU_MISALIGN_CHECK_EN
// Revision : 1.0 - initial release
// =============================================================================
module ifu_fetch #(
   parameter int          XLEN     = 64,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2,
      ST_VALID = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic            w_req_valid;
   logic            w_misalign;
   logic [31:0]     w_sel_word;
   logic [XLEN-1:0] r_fetch_pc;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_inst_pc;
   logic            r_inst_valid;

`ifdef IFU_MISALIGN_CHECK_EN
   logic            r_misalign;
   assign w_misalign          = (bus.pc_i[1:0] != 2'b00);
   assign bus.inst_misalign_o = r_misalign;
`else
   logic            w_unused_nop;
   assign w_misalign   = 1'b0;
   assign w_unused_nop = ^NOP_INST;
`endif

   assign w_sel_word = r_fetch_pc[2] ? bus.mem_rsp_data_i[63:32]
                                     : bus.mem_rsp_data_i[31:0];

   always_comb begin
      w_next_state = r_state;
      w_req_valid  = 1'b0;
      case (r_state)
         ST_REQ: begin
            w_req_valid = ~w_misalign;
            if (w_misalign) begin
               if (!bus.flush_valid_i) w_next_state = ST_VALID;
            end else if (bus.mem_req_ready_i) begin
               // An accepted request is still in flight, so a flush must drain it
               w_next_state = bus.flush_valid_i ? ST_DROP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_rsp_valid_i)    w_next_state = bus.flush_valid_i ? ST_REQ : ST_VALID;
            else if (bus.flush_valid_i) w_next_state = ST_DROP;
         end
         ST_DROP: begin
            if (bus.mem_rsp_valid_i) w_next_state = ST_REQ;
         end
         ST_VALID: begin
            if (bus.id_ready_i || bus.flush_valid_i) w_next_state = ST_REQ;
         end
         default: w_next_state = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_REQ;
         r_fetch_pc   <= '0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
         r_misalign   <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_REQ && w_req_valid && bus.mem_req_ready_i) begin
            r_fetch_pc <= bus.pc_i;
         end
         if (r_state == ST_WAIT && bus.mem_rsp_valid_i && !bus.flush_valid_i) begin
            r_inst       <= w_sel_word;
            r_inst_pc    <= r_fetch_pc;
            r_inst_valid <= 1'b1;
         end
         if (r_state == ST_VALID && (bus.id_ready_i || bus.flush_valid_i)) begin
            r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
         end
`ifdef IFU_MISALIGN_CHECK_EN
         // Misaligned PC never reaches the bus; ID receives a tagged NOP instead
         if (r_state == ST_REQ && w_misalign && !bus.flush_valid_i) begin
            r_inst       <= NOP_INST;
            r_inst_pc    <= bus.pc_i;
            r_inst_valid <= 1'b1;
            r_misalign   <= 1'b1;
         end
`endif
      end
   end

   assign bus.stall_req_o     = ~((r_inst_valid & bus.id_ready_i) | bus.flush_valid_i);
   assign bus.mem_req_valid_o = w_req_valid;
   assign bus.mem_addr_o      = {bus.pc_i[XLEN-1:3], 3'b000};
   assign bus.inst_valid_o    = r_inst_valid;
   assign bus.inst_o          = r_inst;
   assign bus.inst_pc_o       = r_inst_pc;

endmodule
`default_nettype wire
